video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen_pkg.sv | 44 ++++
 rtl/video_timing_gen_pix_ce_gen.sv | 57 +++++
 rtl/video_timing_gen.sv | 145 ++++++++++++++
 tb/tb_video_timing_gen.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_gen_pkg.sv
// Shared video definitions: default raster timing, pixel-clock divide-code
// decode and the packed sync/blank flag bundle used by the timing generator
// and the video pipeline.
package video_timing_gen_pkg;

    // Default raster timing (pixels per line / lines per frame).
    localparam int unsigned DEF_H_ACTIVE    = 320;
    localparam int unsigned DEF_H_FP        = 8;
    localparam int unsigned DEF_H_SYNC      = 32;
    localparam int unsigned DEF_H_BP        = 24;
    localparam int unsigned DEF_V_ACTIVE    = 224;
    localparam int unsigned DEF_V_FP        = 16;
    localparam int unsigned DEF_V_SYNC      = 8;
    localparam int unsigned DEF_V_BP        = 16;
    localparam int unsigned DEF_CNT_WIDTH   = 10;
    localparam int unsigned DEF_COLOR_DEPTH = 6;

    // Divider code and ratio widths (ratio spans 2..8).
    localparam int unsigned CE_CODE_W = 3;
    localparam int unsigned DIV_N_W   = 4;

    // Ratio in force out of reset and for code 0.
    localparam logic [DIV_N_W-1:0] DIV_N_RESET = DIV_N_W'(4);

    // Registered sync/blank decode of one pixel position.
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hblank;
        logic vblank;
    } sync_flags_t;

    // Divide code to clk_sys cycles per pixel: 0 -> 4, otherwise code + 1.
    function automatic logic [DIV_N_W-1:0] ce_div_ratio(input logic [CE_CODE_W-1:0] code);
        logic [DIV_N_W-1:0] ratio;
        if (code == '0) begin
            ratio = DIV_N_RESET;
        end else begin
            ratio = DIV_N_W'(code) + DIV_N_W'(1);
        end
        return ratio;
    endfunction

endpackage

// File: rtl/video_timing_gen_pix_ce_gen.sv
// Pixel clock-enable generator.
// A divider counter runs 0..N-1 on clk_sys and pixel_ena is high exactly
// while the counter sits at N-1. The ratio N is re-latched from ce_divider
// only on the pixel that ends a line, so pixel pitch is constant per line.
// Ports:
//   clk_sys            master clock
//   rst_n              asynchronous active-low reset
//   ce_divider         divide code (decoded by ce_div_ratio)
//   line_end           current pixel position is the last of the line
//   pixel_ena          registered one-cycle pixel strobe
//   pixel_ena_early_c  combinational value pixel_ena takes at the next edge
module video_timing_gen_pix_ce_gen
    import video_timing_gen_pkg::*;
(
    input  logic                 clk_sys,
    input  logic                 rst_n,
    input  logic [CE_CODE_W-1:0] ce_divider,
    input  logic                 line_end,
    output logic                 pixel_ena,
    output logic                 pixel_ena_early_c
);

    localparam int unsigned DIV_CNT_W = 3;

    logic [DIV_CNT_W-1:0] div_cnt;
    logic [DIV_CNT_W-1:0] div_cnt_nxt;
    logic [DIV_N_W-1:0]   div_n;
    logic [DIV_N_W-1:0]   div_n_nxt;

    // Next divider state; the strobe is derived from the next count so it
    // stays registered yet coincides with count == N-1.
    always_comb begin
        div_n_nxt   = div_n;
        div_cnt_nxt = div_cnt + DIV_CNT_W'(1);
        if (pixel_ena) begin
            div_cnt_nxt = '0;
            if (line_end) begin
                div_n_nxt = ce_div_ratio(ce_divider);
            end
        end
        pixel_ena_early_c = (DIV_N_W'(div_cnt_nxt) == (div_n_nxt - DIV_N_W'(1)));
    end

    // Divider state registers.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt   <= '0;
            div_n     <= DIV_N_RESET;
            pixel_ena <= 1'b0;
        end else begin
            div_cnt   <= div_cnt_nxt;
            div_n     <= div_n_nxt;
            pixel_ena <= pixel_ena_early_c;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator.
// Produces the pixel strobe, horizontal/vertical position counters, sync and
// blanking pulses, blank-gated colour and a start-of-frame pulse. Sync, blank
// and colour are decoded from the position and core colour on each pixel
// strobe and registered, so they lag hcnt/vcnt by one pixel.
// Ports:
//   clk_sys              master clock (shared with the video pipeline)
//   rst_n                asynchronous active-low reset
//   ce_divider           pixel clock divide code, applied at line end
//   r_in/g_in/b_in       core colour for the current hcnt/vcnt
//   pixel_ena            one-clk_sys pixel strobe
//   hcnt/vcnt            current pixel / line position
//   R/G/B                blank-gated colour
//   HSync/VSync          active-high sync
//   HBlank/VBlank        active-high blanking
//   frame_start          one-clk_sys pulse on the strobe presenting (0,0)
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = DEF_H_ACTIVE,
    parameter int unsigned H_FP        = DEF_H_FP,
    parameter int unsigned H_SYNC      = DEF_H_SYNC,
    parameter int unsigned H_BP        = DEF_H_BP,
    parameter int unsigned V_ACTIVE    = DEF_V_ACTIVE,
    parameter int unsigned V_FP        = DEF_V_FP,
    parameter int unsigned V_SYNC      = DEF_V_SYNC,
    parameter int unsigned V_BP        = DEF_V_BP,
    parameter int unsigned CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int unsigned COLOR_DEPTH = DEF_COLOR_DEPTH
) (
    input  logic                   clk_sys,
    input  logic                   rst_n,
    input  logic [CE_CODE_W-1:0]   ce_divider,
    input  logic [COLOR_DEPTH-1:0] r_in,
    input  logic [COLOR_DEPTH-1:0] g_in,
    input  logic [COLOR_DEPTH-1:0] b_in,
    output logic                   pixel_ena,
    output logic [CNT_WIDTH-1:0]   hcnt,
    output logic [CNT_WIDTH-1:0]   vcnt,
    output logic [COLOR_DEPTH-1:0] R,
    output logic [COLOR_DEPTH-1:0] G,
    output logic [COLOR_DEPTH-1:0] B,
    output logic                   HSync,
    output logic                   VSync,
    output logic                   HBlank,
    output logic                   VBlank,
    output logic                   frame_start
);

    localparam int unsigned H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START   = H_ACTIVE + H_FP;
    localparam int unsigned HS_END     = HS_START + H_SYNC;
    localparam int unsigned VS_START   = V_ACTIVE + V_FP;
    localparam int unsigned VS_END     = VS_START + V_SYNC;
    localparam longint unsigned CNT_RANGE = 64'd1 << CNT_WIDTH;

    // Raster totals must be representable in the position counters.
    if ((64'(H_TOTAL) > CNT_RANGE) || (64'(V_TOTAL) > CNT_RANGE)) begin : g_bad_cnt_width
        $error("video_timing_gen: raster totals do not fit CNT_WIDTH");
    end

    localparam logic [CNT_WIDTH-1:0] H_LAST   = CNT_WIDTH'(H_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] V_LAST   = CNT_WIDTH'(V_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] H_ACT_C  = CNT_WIDTH'(H_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] V_ACT_C  = CNT_WIDTH'(V_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] HS_STA_C = CNT_WIDTH'(HS_START);
    localparam logic [CNT_WIDTH-1:0] HS_END_C = CNT_WIDTH'(HS_END);
    localparam logic [CNT_WIDTH-1:0] VS_STA_C = CNT_WIDTH'(VS_START);
    localparam logic [CNT_WIDTH-1:0] VS_END_C = CNT_WIDTH'(VS_END);

    logic        line_end_c;
    logic        pixel_ena_early_c;
    sync_flags_t flags_c;
    logic        blank_c;
    sync_flags_t sync_q;

    assign line_end_c = (hcnt == H_LAST);

    // Pixel strobe and per-line divide ratio.
    video_timing_gen_pix_ce_gen u_pix_ce_gen (
        .clk_sys           (clk_sys),
        .rst_n             (rst_n),
        .ce_divider        (ce_divider),
        .line_end          (line_end_c),
        .pixel_ena         (pixel_ena),
        .pixel_ena_early_c (pixel_ena_early_c)
    );

    // Position counters; vcnt steps only on the strobe that wraps hcnt.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (pixel_ena) begin
            if (line_end_c) begin
                hcnt <= '0;
                vcnt <= (vcnt == V_LAST) ? '0 : vcnt + CNT_WIDTH'(1);
            end else begin
                hcnt <= hcnt + CNT_WIDTH'(1);
            end
        end
    end

    // Sync/blank decode of the position currently presented.
    always_comb begin
        flags_c        = '0;
        flags_c.hblank = (hcnt >= H_ACT_C);
        flags_c.vblank = (vcnt >= V_ACT_C);
        flags_c.hsync  = (hcnt >= HS_STA_C) && (hcnt < HS_END_C);
        flags_c.vsync  = (vcnt >= VS_STA_C) && (vcnt < VS_END_C);
        blank_c        = flags_c.hblank || flags_c.vblank;
    end

    // Decoded outputs advance once per pixel, one pixel behind hcnt/vcnt.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            R      <= '0;
            G      <= '0;
            B      <= '0;
        end else if (pixel_ena) begin
            sync_q <= flags_c;
            R      <= blank_c ? '0 : r_in;
            G      <= blank_c ? '0 : g_in;
            B      <= blank_c ? '0 : b_in;
        end
    end

    assign HSync  = sync_q.hsync;
    assign VSync  = sync_q.vsync;
    assign HBlank = sync_q.hblank;
    assign VBlank = sync_q.vblank;

    // Counters are static on the edge that raises pixel_ena, so the
    // position seen here is the one the strobe will present.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pixel_ena_early_c && (hcnt == '0) && (vcnt == '0);
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen: a cycle-level raster model in the
// driver predicts every pixel strobe (clock index, position, frame_start and
// the one-pixel-late decoded outputs); a monitor compares on each strobe.
module tb_video_timing_gen;

    localparam int unsigned H_ACTIVE = 320;
    localparam int unsigned H_FP     = 8;
    localparam int unsigned H_SYNC   = 32;
    localparam int unsigned H_BP     = 24;
    localparam int unsigned V_ACTIVE = 4;
    localparam int unsigned V_FP     = 2;
    localparam int unsigned V_SYNC   = 2;
    localparam int unsigned V_BP     = 2;
    localparam int unsigned CW       = 10;
    localparam int unsigned CD       = 6;
    localparam int H_TOT = int'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int V_TOT = int'(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int STEP_LIMIT = 60000;

    typedef struct packed {
        logic [31:0]   cyc;
        logic [CW-1:0] hc;
        logic [CW-1:0] vc;
        logic          fs;
        logic [CD-1:0] r;
        logic [CD-1:0] g;
        logic [CD-1:0] b;
        logic          hs;
        logic          vs;
        logic          hb;
        logic          vb;
    } pix_t;

    logic          clk_sys;
    logic          rst_n;
    logic [2:0]    ce_divider;
    logic [CD-1:0] r_in, g_in, b_in;
    logic          pixel_ena;
    logic [CW-1:0] hcnt, vcnt;
    logic [CD-1:0] R, G, B;
    logic          HSync, VSync, HBlank, VBlank;
    logic          frame_start;

    video_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CNT_WIDTH(CW), .COLOR_DEPTH(CD)
    ) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .ce_divider(ce_divider),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .pixel_ena(pixel_ena), .hcnt(hcnt), .vcnt(vcnt),
        .R(R), .G(G), .B(B),
        .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
        .frame_start(frame_start)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    // Clock edges since the last reset release.
    int cyc;
    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    pix_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   fs_seen  = 0;
    int   fs_exp   = 0;

    // Reference model state.
    int   m_h, m_v, m_n, m_frames, next_pulse;
    pix_t prev;
    bit   rand_ce, rgb_const, aborted;

    function automatic int ratio(input int code);
        return (code == 0) ? 4 : code + 1;
    endfunction

    // Outputs the DUT should show after decoding pixel (h,v) with colour rgb.
    function automatic pix_t decode(input int h, input int v,
                                    input logic [CD-1:0] r, input logic [CD-1:0] g,
                                    input logic [CD-1:0] b);
        pix_t d;
        d    = '0;
        d.hb = (h >= int'(H_ACTIVE));
        d.vb = (v >= int'(V_ACTIVE));
        d.hs = (h >= int'(H_ACTIVE + H_FP)) && (h < int'(H_ACTIVE + H_FP + H_SYNC));
        d.vs = (v >= int'(V_ACTIVE + V_FP)) && (v < int'(V_ACTIVE + V_FP + V_SYNC));
        if (!(d.hb || d.vb)) begin
            d.r = r;
            d.g = g;
            d.b = b;
        end
        return d;
    endfunction

    task automatic model_reset();
        m_h        = 0;
        m_v        = 0;
        m_n        = 4;
        m_frames   = 0;
        next_pulse = m_n - 1;
        prev       = '0;
    endtask

    // One clock: drive fresh inputs and, on a predicted strobe, queue its
    // expectation and advance the raster.
    task automatic step();
        pix_t e;
        @(posedge clk_sys);
        #1;
        if (rand_ce && ($urandom_range(0, 299) == 0)) ce_divider = 3'($urandom_range(0, 3));
        if (rgb_const) begin
            r_in = '1; g_in = '1; b_in = '1;
        end else begin
            r_in = CD'($urandom); g_in = CD'($urandom); b_in = CD'($urandom);
        end
        if (cyc == next_pulse) begin
            e     = prev;
            e.cyc = 32'(cyc);
            e.hc  = CW'(m_h);
            e.vc  = CW'(m_v);
            e.fs  = (m_h == 0) && (m_v == 0);
            exp_q.push_back(e);
            if (e.fs) fs_exp++;
            prev = decode(m_h, m_v, r_in, g_in, b_in);
            m_h++;
            if (m_h == H_TOT) begin
                m_h = 0;
                m_n = ratio(int'(ce_divider));
                m_v++;
                if (m_v == V_TOT) begin
                    m_v = 0;
                    m_frames++;
                end
            end
            next_pulse = cyc + m_n;
        end
    endtask

    task automatic run_until(input int fr, input int v, input int h);
        int n;
        n = 0;
        while (!aborted && !(m_frames == fr && m_v == v && m_h == h)) begin
            step();
            n++;
            if (n > STEP_LIMIT) begin
                checks++;
                failures++;
                $display("FAIL run_until timeout: at frame %0d v %0d h %0d, want frame %0d v %0d h %0d",
                         m_frames, m_v, m_h, fr, v, h);
                aborted = 1'b1;
            end
        end
    endtask

    // Monitor: compare every strobe against the head of the scoreboard.
    always @(negedge clk_sys) begin
        pix_t act, e;
        if (!rst_n) begin
            checks++;
            if ({pixel_ena, frame_start, hcnt, vcnt, R, G, B, HSync, VSync, HBlank, VBlank} != '0) begin
                failures++;
                $display("FAIL reset_state: pe=%b fs=%b h=%0d v=%0d rgb=%h/%h/%h hs=%b vs=%b hb=%b vb=%b, want all 0",
                         pixel_ena, frame_start, hcnt, vcnt, R, G, B, HSync, VSync, HBlank, VBlank);
            end
        end else if (pixel_ena) begin
            act     = '0;
            act.cyc = 32'(cyc);
            act.hc  = hcnt;  act.vc = vcnt;  act.fs = frame_start;
            act.r   = R;     act.g  = G;     act.b  = B;
            act.hs  = HSync; act.vs = VSync; act.hb = HBlank; act.vb = VBlank;
            if (frame_start) fs_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pixel: cyc=%0d h=%0d v=%0d, no strobe expected", cyc, hcnt, vcnt);
            end else begin
                e = exp_q.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL pixel: got cyc=%0d h=%0d v=%0d fs=%b rgb=%h/%h/%h hs=%b vs=%b hb=%b vb=%b; want cyc=%0d h=%0d v=%0d fs=%b rgb=%h/%h/%h hs=%b vs=%b hb=%b vb=%b",
                             act.cyc, act.hc, act.vc, act.fs, act.r, act.g, act.b, act.hs, act.vs, act.hb, act.vb,
                             e.cyc, e.hc, e.vc, e.fs, e.r, e.g, e.b, e.hs, e.vs, e.hb, e.vb);
                end
            end
        end else begin
            if (frame_start) begin
                checks++;
                failures++;
                $display("FAIL frame_start_alone: frame_start=1 without pixel_ena at cyc=%0d", cyc);
            end
            if (exp_q.size() != 0 && int'(exp_q[0].cyc) <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_pixel: pixel_ena=0 at cyc=%0d, want strobe for h=%0d v=%0d",
                         cyc, e.hc, e.vc);
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        ce_divider = 3'd0;
        r_in = '0; g_in = '0; b_in = '0;
        rand_ce = 1'b0; rgb_const = 1'b0; aborted = 1'b0;
        model_reset();
        repeat (4) @(negedge clk_sys);
        rst_n = 1'b1;

        // Divide change mid-line: pitch 4 holds until the wrap, then 2.
        run_until(0, 0, 101);
        ce_divider = 3'd1;
        run_until(0, 2, 0);
        rand_ce = 1'b1;

        // Saturated colour for part of the second frame.
        run_until(1, 0, 0);
        rgb_const = 1'b1;
        run_until(1, 6, 0);
        rgb_const = 1'b0;

        // Asynchronous reset mid-line, mid-frame.
        run_until(2, 7, 201);
        @(posedge clk_sys);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pixel_ena, frame_start, hcnt, vcnt, R, G, B, HSync, VSync, HBlank, VBlank} != '0) begin
            failures++;
            $display("FAIL async_reset: pe=%b fs=%b h=%0d v=%0d rgb=%h/%h/%h sync/blank=%b%b%b%b, want all 0",
                     pixel_ena, frame_start, hcnt, vcnt, R, G, B, HSync, VSync, HBlank, VBlank);
        end
        exp_q.delete();
        model_reset();
        rand_ce = 1'b0;
        ce_divider = 3'd2;
        repeat (3) @(negedge clk_sys);
        rst_n = 1'b1;
        run_until(0, 1, 5);
        repeat (2) @(negedge clk_sys);

        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: %0d strobes still pending, want 0", exp_q.size());
        end
        checks++;
        if (fs_seen != fs_exp) begin
            failures++;
            $display("FAIL frame_start_count: got %0d, want %0d", fs_seen, fs_exp);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
